// File: rtl/qfmt_pkg.sv
// Shared sign-magnitude Q-format definitions: multiplier FSM states and the
// default field geometry used by qmult_seq and downstream qadd consumers.
package qfmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } qmult_state_t;

  localparam int QFMT_N        = 32;
  localparam int QFMT_Q        = 15;
  localparam int QFMT_SIGN_IDX = QFMT_N - 1;
  localparam int QFMT_MAG_W    = QFMT_N - 1;

endpackage

// File: rtl/qmult_seq_pack.sv
// Result packer: takes the product bits above the fraction cut, applies the
// round increment, saturates to the magnitude range and suppresses negative zero.
module qmult_seq_pack
  import qfmt_pkg::*;
#(
  parameter int Q = QFMT_Q,
  parameter int N = QFMT_N
) (
  input  logic [2*(N-1)-Q-1:0] prod_hi,
  input  logic                 rnd,
  input  logic                 sign,
  output logic [N-1:0]         c,
  output logic                 ovf
);

  localparam int MW = N - 1;
  localparam int HW = MW - Q;

  // Extra top bit catches the carry out of the round increment.
  function automatic logic [MW:0] round_mag(input logic [MW-1:0] field, input logic inc);
    return {1'b0, field} + {{MW{1'b0}}, inc};
  endfunction

  // Returns {ovf, magnitude}.
  function automatic logic [MW:0] saturate(input logic [MW:0] r, input logic hi_nz);
    if (hi_nz || r[MW]) return {1'b1, {MW{1'b1}}};
    return {1'b0, r[MW-1:0]};
  endfunction

  logic [MW:0] rounded;
  logic [MW:0] sat;

  always_comb begin
    rounded = round_mag(prod_hi[MW-1:0], rnd);
    sat     = saturate(rounded, |prod_hi[MW+HW-1:MW]);
    ovf     = sat[MW];
    c       = {sign & (|sat[MW-1:0]), sat[MW-1:0]};
  end

endmodule

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Q-format multiplier, radix-2 shift-add over N-1 cycles.
// Define QMULT_SEQ_ROUND_EN for round-half-up of the magnitude; default truncates.
module qmult_seq
  import qfmt_pkg::*;
#(
  parameter int Q = QFMT_Q,
  parameter int N = QFMT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int MW = N - 1;
  localparam int PW = 2 * MW;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 2);

  qmult_state_t state;
  qmult_state_t state_nx;

  logic [PW-1:0] mcand;
  logic [PW-1:0] prod;
  logic [MW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic          sign;
  logic          accept;
  logic          rnd;
  logic [N-1:0]  c_pk;
  logic          ovf_pk;

  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MUL;
      MUL:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result is forced to zero outside DONE so no partial product ever leaks out.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    c         = out_valid ? c_pk : '0;
    ovf       = out_valid & ovf_pk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else if (accept) begin
      mcand  <= {{MW{1'b0}}, a[MW-1:0]};
      mplier <= b[MW-1:0];
      prod   <= '0;
      cnt    <= '0;
      sign   <= a[N-1] ^ b[N-1];
    end else if (state == MUL) begin
      if (mplier[0]) prod <= prod + mcand;
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      cnt    <= cnt + 1'b1;
    end
  end

`ifdef QMULT_SEQ_ROUND_EN
  generate
    if (Q > 0) begin : g_rnd
      assign rnd = prod[Q-1];
    end else begin : g_no_rnd
      assign rnd = 1'b0;
    end
  endgenerate
`else
  assign rnd = 1'b0;
`endif

  qmult_seq_pack #(
    .Q(Q),
    .N(N)
  ) u_pack (
    .prod_hi (prod[PW-1:Q]),
    .rnd     (rnd),
    .sign    (sign),
    .c       (c_pk),
    .ovf     (ovf_pk)
  );

endmodule

// File: tb/tb_qmult_seq.sv
// Bench for qmult_seq: directed vector table, handshake/reset sequences and
// random operands against an arithmetic reference model.
module tb_qmult_seq;

  localparam int N = 32;
  localparam int Q = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] c;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qmult_seq #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Product from plain integer arithmetic: returns {ovf, c}.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [63:0] m;
    logic        o;
    logic        s;
    p = {33'b0, x[30:0]} * {33'b0, y[30:0]};
    m = p >> Q;
`ifdef QMULT_SEQ_ROUND_EN
    m = m + ((p >> (Q - 1)) & 64'd1);
`endif
    o = (m > 64'h7FFF_FFFF);
    if (o) m = 64'h7FFF_FFFF;
    s = (m == 64'd0) ? 1'b0 : (x[31] ^ y[31]);
    return {o, s, m[30:0]};
  endfunction

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_);
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check("in_ready after accept", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready after handshake", 64'(in_ready), 64'd1);
    check("out_valid after handshake", 64'(out_valid), 64'd0);
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_,
                       output logic [31:0] rc, output logic rovf, output int lat);
    start_op(ta, tb_);
    wait_done(lat);
    rc = c;
    rovf = ovf;
    consume();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rc;
    logic        rovf;
    int          lat;
    logic [32:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] held;

    vecs.push_back('{32'h0000C000, 32'h00010000, 32'h00018000, 1'b0});
    vecs.push_back('{32'h8000C000, 32'h00010000, 32'h80018000, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00010000, 32'h00000000, 1'b0});
`ifdef QMULT_SEQ_ROUND_EN
    vecs.push_back('{32'h00000001, 32'h00004000, 32'h00000001, 1'b0});
`else
    vecs.push_back('{32'h00000001, 32'h00004000, 32'h00000000, 1'b0});
`endif
    vecs.push_back('{32'h80000001, 32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{32'h80008000, 32'h80008000, 32'h00008000, 1'b0});
    vecs.push_back('{32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b0});

    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset c", 64'(c), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, rc, rovf, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd31);
      check($sformatf("vec%0d c", i), 64'(rc), 64'(vecs[i].c));
      check($sformatf("vec%0d ovf", i), 64'(rovf), 64'(vecs[i].ovf));
    end

    // Backpressure: result held for 10 cycles while in_valid is ignored.
    start_op(32'h0000C000, 32'h00010000);
    wait_done(lat);
    check("bp latency", 64'(lat), 64'd31);
    held = c;
    check("bp c", 64'(held), 64'h00018000);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d c stable", k), 64'(c), 64'(held));
      check($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'd1);
    end
    ra = 32'h00008000;
    rb = 32'h00018000;
    a = ra;
    b = rb;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle in_ready", 64'(in_ready), 64'd1);
    check("bp idle out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check("bp next accepted", 64'(in_ready), 64'd0);
    wait_done(lat);
    check("bp next latency", 64'(lat), 64'd31);
    check("bp next c", 64'(c), 64'h00018000);
    consume();

    // Reset mid-MUL discards the operation at once.
    start_op(32'h7FFFFFFF, 32'h7FFFFFFF);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("rst mul out_valid", 64'(out_valid), 64'd0);
    check("rst mul in_ready", 64'(in_ready), 64'd1);
    check("rst mul c", 64'(c), 64'd0);
    check("rst mul ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h0000C000, 32'h80010000, rc, rovf, lat);
    check("post rst latency", 64'(lat), 64'd31);
    check("post rst c", 64'(rc), 64'h80018000);

    // Reset while a saturated result is pending in DONE.
    start_op(32'hFFFFFFFF, 32'h00010000);
    wait_done(lat);
    check("rst done pre ovf", 64'(ovf), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst done out_valid", 64'(out_valid), 64'd0);
    check("rst done c", 64'(c), 64'd0);
    check("rst done ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[30:0] = ra[30:0] >> $urandom_range(0, 30);
      rb[30:0] = rb[30:0] >> $urandom_range(0, 30);
      m = model(ra, rb);
      do_op(ra, rb, rc, rovf, lat);
      check($sformatf("rnd%0d latency", i), 64'(lat), 64'd31);
      check($sformatf("rnd%0d c a=%h b=%h", i, ra, rb), 64'(rc), 64'(m[31:0]));
      check($sformatf("rnd%0d ovf", i), 64'(rovf), 64'(m[32]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
